// File: rtl/clock_div_prog_multi.sv
// Multi-channel programmable clock divider: per-channel square wave, period tick,
// glitch-free divisor updates at period boundaries, and a global re-phase strobe.
module clock_div_prog_multi #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned DEFAULT_DIV = 100000
) (
  input  logic              CLK_IN,
  input  logic              RESET,
  input  logic              DIV_WR,
  input  logic [2:0]        DIV_CH,
  input  logic [CNT_W-1:0]  DIV_DATA,
  input  logic              SYNC,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] PENDING,
  output logic              DIV_ERR
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  div_act  [NUM_CH];
  logic [CNT_W-1:0]  div_pend [NUM_CH];
  logic [CNT_W-1:0]  cnt_n    [NUM_CH];
  logic [CNT_W-1:0]  act_n    [NUM_CH];
  logic [CNT_W-1:0]  pval_n   [NUM_CH];
  logic [CNT_W-1:0]  half_n   [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] pend_n;
  logic [NUM_CH-1:0] clk_n;
  logic [NUM_CH-1:0] tick_n;
  logic              wr_ok;
  logic              err_n;

  assign wr_ok = DIV_WR && (32'(DIV_CH) < NUM_CH);
  assign err_n = DIV_ERR | (wr_ok && (DIV_DATA < TWO));

  always_comb begin
    hit    = '0;
    pend_n = '0;
    clk_n  = '0;
    tick_n = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]    = wr_ok && (32'(DIV_CH) == i);
      cnt_n[i]  = cnt[i] + ONE;
      act_n[i]  = div_act[i];
      pval_n[i] = hit[i] ? DIV_DATA : div_pend[i];
      pend_n[i] = PENDING[i] | hit[i];
      // A disabled channel (divisor < 2) has no boundary, so it takes a
      // same-cycle write directly, just like SYNC does.
      if (SYNC || (div_act[i] < TWO)) begin
        cnt_n[i] = '0;
        if (hit[i]) begin
          act_n[i]  = DIV_DATA;
          pend_n[i] = 1'b0;
        end else if (PENDING[i]) begin
          act_n[i]  = div_pend[i];
          pend_n[i] = 1'b0;
        end
      end else if (cnt[i] == div_act[i] - ONE) begin
        cnt_n[i] = '0;
        if (PENDING[i]) begin
          act_n[i]  = div_pend[i];
          pend_n[i] = hit[i];
        end
      end
      half_n[i] = (act_n[i] >> 1) + {{(CNT_W-1){1'b0}}, act_n[i][0]};
      clk_n[i]  = (act_n[i] >= TWO) && (cnt_n[i] < half_n[i]);
      tick_n[i] = (act_n[i] >= TWO) && (cnt_n[i] == act_n[i] - ONE);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        div_act[i]  <= DEF;
        div_pend[i] <= DEF;
      end
      CLK_OUT <= '1;
      TICK    <= '0;
      PENDING <= '0;
      DIV_ERR <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_act  <= act_n;
      div_pend <= pval_n;
      CLK_OUT  <= clk_n;
      TICK     <= tick_n;
      PENDING  <= pend_n;
      DIV_ERR  <= err_n;
    end
  end

endmodule

// File: tb/tb_clock_div_prog_multi.sv
// Self-checking bench for clock_div_prog_multi: directed scenarios plus random
// traffic compared against an integer period/phase reference model.
module tb_clock_div_prog_multi;

  localparam int NCH = 2;
  localparam int DEF = 4;

  logic           CLK_IN = 1'b0;
  logic           RESET = 1'b0;
  logic           DIV_WR = 1'b0;
  logic [2:0]     DIV_CH = '0;
  logic [7:0]     DIV_DATA = '0;
  logic           SYNC = 1'b0;
  logic [NCH-1:0] CLK_OUT;
  logic [NCH-1:0] TICK;
  logic [NCH-1:0] PENDING;
  logic           DIV_ERR;

  int checks = 0;
  int errors = 0;

  // Reference model: phase within the current period, its length, and the
  // queued next length (-1 when nothing is queued).
  int m_phase [NCH];
  int m_div   [NCH];
  int m_nxt   [NCH];
  bit m_err;

  clock_div_prog_multi #(.NUM_CH(NCH), .CNT_W(8), .DEFAULT_DIV(DEF)) dut (
    .CLK_IN(CLK_IN), .RESET(RESET), .DIV_WR(DIV_WR), .DIV_CH(DIV_CH),
    .DIV_DATA(DIV_DATA), .SYNC(SYNC), .CLK_OUT(CLK_OUT), .TICK(TICK),
    .PENDING(PENDING), .DIV_ERR(DIV_ERR)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic model_update(input bit rst, input bit wr, input int ch, input int data, input bit sync);
    for (int c = 0; c < NCH; c++) begin
      bit h;
      h = wr && (ch == c);
      if (rst) begin
        m_phase[c] = 0; m_div[c] = DEF; m_nxt[c] = -1;
      end else if (sync || m_div[c] < 2) begin
        m_phase[c] = 0;
        if (h) begin m_div[c] = data; m_nxt[c] = -1; end
        else if (m_nxt[c] >= 0) begin m_div[c] = m_nxt[c]; m_nxt[c] = -1; end
      end else begin
        m_phase[c] = m_phase[c] + 1;
        if (m_phase[c] == m_div[c]) begin
          m_phase[c] = 0;
          if (m_nxt[c] >= 0) begin m_div[c] = m_nxt[c]; m_nxt[c] = -1; end
        end
        if (h) m_nxt[c] = data;
      end
    end
    if (rst) m_err = 0;
    else if (wr && ch < NCH && data < 2) m_err = 1;
  endtask

  function automatic logic [6:0] model_out();
    logic [NCH-1:0] c, t, p;
    for (int k = 0; k < NCH; k++) begin
      c[k] = (m_div[k] >= 2) && (m_phase[k] < (m_div[k] + 1) / 2);
      t[k] = (m_div[k] >= 2) && (m_phase[k] == m_div[k] - 1);
      p[k] = (m_nxt[k] >= 0);
    end
    return {c, t, p, m_err};
  endfunction

  task automatic step(input bit rst, input bit wr, input logic [2:0] ch, input logic [7:0] data, input bit sync);
    @(negedge CLK_IN);
    RESET = rst; DIV_WR = wr; DIV_CH = ch; DIV_DATA = data; SYNC = sync;
    @(posedge CLK_IN);
    model_update(rst, wr, int'(ch), int'(data), sync);
    #1;
    RESET = 1'b0; DIV_WR = 1'b0; SYNC = 1'b0;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    checks++; if (CLK_OUT !== 2'b11) begin errors++; $display("FAIL reset_clk: got %b want 11", CLK_OUT); end
    checks++; if (TICK !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b want 00", TICK); end
    checks++; if (PENDING !== 2'b00) begin errors++; $display("FAIL reset_pend: got %b want 00", PENDING); end
    checks++; if (DIV_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", DIV_ERR); end
  endtask

  task automatic test_default_pattern;
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] ec, et;
      step(0, 0, 0, 0, 0);
      ec = ((k % 4) < 2) ? 2'b11 : 2'b00;
      et = ((k % 4) == 3) ? 2'b11 : 2'b00;
      checks++; if (CLK_OUT !== ec) begin errors++; $display("FAIL default_clk[%0d]: got %b want %b", k, CLK_OUT, ec); end
      checks++; if (TICK !== et) begin errors++; $display("FAIL default_tick[%0d]: got %b want %b", k, TICK, et); end
    end
  endtask

  task automatic test_midperiod_write;
    logic [4:0] pc, pt;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 5, 0);
    checks++; if (PENDING !== 2'b01) begin errors++; $display("FAIL mid_pend_set: got %b want 01", PENDING); end
    step(0, 0, 0, 0, 0);
    checks++; if (TICK !== 2'b11) begin errors++; $display("FAIL mid_old_tick: got %b want 11", TICK); end
    step(0, 0, 0, 0, 0);
    checks++; if (PENDING !== 2'b00) begin errors++; $display("FAIL mid_pend_clr: got %b want 00", PENDING); end
    pc = {4'b0, CLK_OUT[0]}; pt = {4'b0, TICK[0]};
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0);
      checks++; if ({CLK_OUT, TICK, PENDING, DIV_ERR} !== model_out()) begin errors++; $display("FAIL mid_model[%0d]: got %b want %b", k, {CLK_OUT, TICK, PENDING, DIV_ERR}, model_out()); end
      pc = {pc[3:0], CLK_OUT[0]}; pt = {pt[3:0], TICK[0]};
    end
    checks++; if (pc !== 5'b11100) begin errors++; $display("FAIL mid_div5_clk: got %b want 11100", pc); end
    checks++; if (pt !== 5'b00001) begin errors++; $display("FAIL mid_div5_tick: got %b want 00001", pt); end
  endtask

  task automatic test_double_write;
    logic [5:0] c0, c1, t0, t1;
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 6, 0);
    step(0, 1, 1, 3, 0);
    checks++; if (PENDING !== 2'b10) begin errors++; $display("FAIL dbl_pend: got %b want 10", PENDING); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (PENDING !== 2'b00) begin errors++; $display("FAIL dbl_pend_clr: got %b want 00", PENDING); end
    c0 = '0; c1 = '0; t0 = '0; t1 = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(0, 0, 0, 0, 0);
      checks++; if ({CLK_OUT, TICK, PENDING, DIV_ERR} !== model_out()) begin errors++; $display("FAIL dbl_model[%0d]: got %b want %b", k, {CLK_OUT, TICK, PENDING, DIV_ERR}, model_out()); end
      c0 = {c0[4:0], CLK_OUT[0]}; c1 = {c1[4:0], CLK_OUT[1]};
      t0 = {t0[4:0], TICK[0]};    t1 = {t1[4:0], TICK[1]};
    end
    checks++; if (c1 !== 6'b110110) begin errors++; $display("FAIL dbl_ch1_clk: got %b want 110110", c1); end
    checks++; if (t1 !== 6'b001001) begin errors++; $display("FAIL dbl_ch1_tick: got %b want 001001", t1); end
    checks++; if (c0 !== 6'b110011) begin errors++; $display("FAIL dbl_ch0_clk: got %b want 110011", c0); end
    checks++; if (t0 !== 6'b000100) begin errors++; $display("FAIL dbl_ch0_tick: got %b want 000100", t0); end
  endtask

  task automatic test_disable;
    int n;
    bit held;
    logic [3:0] pc, pt;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++; if (DIV_ERR !== 1'b1) begin errors++; $display("FAIL dis_err: got %b want 1", DIV_ERR); end
    n = 0;
    while (PENDING[0] !== 1'b0 && n < 8) begin step(0, 0, 0, 0, 0); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL dis_boundary: got %0d cycles want 3", n); end
    held = 1;
    for (int k = 0; k < 6; k++) begin
      if (CLK_OUT[0] !== 1'b0 || TICK[0] !== 1'b0) held = 0;
      step(0, 0, 0, 0, 0);
    end
    checks++; if (!held) begin errors++; $display("FAIL dis_held: got clk/tick activity want both held 0"); end
    step(0, 1, 0, 4, 0);
    checks++; if (CLK_OUT[0] !== 1'b1 || PENDING[0] !== 1'b0) begin errors++; $display("FAIL dis_reenable: got clk=%b pend=%b want clk=1 pend=0", CLK_OUT[0], PENDING[0]); end
    pc = {3'b0, CLK_OUT[0]}; pt = {3'b0, TICK[0]};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      pc = {pc[2:0], CLK_OUT[0]}; pt = {pt[2:0], TICK[0]};
    end
    checks++; if (pc !== 4'b1100 || pt !== 4'b0001) begin errors++; $display("FAIL dis_period4: got clk=%b tick=%b want 1100/0001", pc, pt); end
    checks++; if (DIV_ERR !== 1'b1) begin errors++; $display("FAIL dis_sticky: got %b want 1", DIV_ERR); end
  endtask

  task automatic test_reset_priority;
    logic [3:0] t0, t1;
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 7, 0);
    checks++; if (PENDING[1] !== 1'b1) begin errors++; $display("FAIL rp_pend_pre: got %b want 1", PENDING[1]); end
    step(1, 1, 0, 9, 1);
    checks++; if (CLK_OUT !== 2'b11) begin errors++; $display("FAIL rp_clk: got %b want 11", CLK_OUT); end
    checks++; if (TICK !== 2'b00) begin errors++; $display("FAIL rp_tick: got %b want 00", TICK); end
    checks++; if (PENDING !== 2'b00) begin errors++; $display("FAIL rp_pend: got %b want 00", PENDING); end
    checks++; if (DIV_ERR !== 1'b0) begin errors++; $display("FAIL rp_err: got %b want 0", DIV_ERR); end
    t0 = {3'b0, TICK[0]}; t1 = {3'b0, TICK[1]};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      t0 = {t0[2:0], TICK[0]}; t1 = {t1[2:0], TICK[1]};
    end
    checks++; if (t0 !== 4'b0001 || t1 !== 4'b0001) begin errors++; $display("FAIL rp_default_div: got %b/%b want 0001/0001", t0, t1); end
  endtask

  task automatic test_sync;
    int f0, f1;
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 3, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0, 0);
      checks++; if ({CLK_OUT, TICK, PENDING, DIV_ERR} !== model_out()) begin errors++; $display("FAIL sync_pre_model[%0d]: got %b want %b", k, {CLK_OUT, TICK, PENDING, DIV_ERR}, model_out()); end
    end
    step(0, 1, 0, 5, 0);
    checks++; if (PENDING[0] !== 1'b1) begin errors++; $display("FAIL sync_pend_pre: got %b want 1", PENDING[0]); end
    step(0, 1, 1, 6, 1);
    checks++; if (CLK_OUT !== 2'b11) begin errors++; $display("FAIL sync_clk: got %b want 11", CLK_OUT); end
    checks++; if (TICK !== 2'b00) begin errors++; $display("FAIL sync_tick: got %b want 00", TICK); end
    checks++; if (PENDING !== 2'b00) begin errors++; $display("FAIL sync_pend: got %b want 00", PENDING); end
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0);
      if (TICK[0] === 1'b1 && f0 < 0) f0 = k;
      if (TICK[1] === 1'b1 && f1 < 0) f1 = k;
    end
    checks++; if (f0 != 4) begin errors++; $display("FAIL sync_ch0_div5: got first tick %0d want 4", f0); end
    checks++; if (f1 != 5) begin errors++; $display("FAIL sync_ch1_div6: got first tick %0d want 5", f1); end
  endtask

  task automatic test_invalid_channel;
    step(1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 3, 1, 0);
    checks++; if (PENDING !== 2'b00 || DIV_ERR !== 1'b0) begin errors++; $display("FAIL inv_ch: got pend=%b err=%b want 00/0", PENDING, DIV_ERR); end
    checks++; if ({CLK_OUT, TICK, PENDING, DIV_ERR} !== model_out()) begin errors++; $display("FAIL inv_model: got %b want %b", {CLK_OUT, TICK, PENDING, DIV_ERR}, model_out()); end
  endtask

  task automatic test_random;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      bit rst, wr, sy;
      logic [2:0] ch;
      logic [7:0] d;
      rst = ($urandom_range(0, 150) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      sy  = ($urandom_range(0, 30) == 0);
      ch  = 3'($urandom_range(0, 3));
      d   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(2, 12));
      step(rst, wr, ch, d, sy);
      checks++; if ({CLK_OUT, TICK, PENDING, DIV_ERR} !== model_out()) begin errors++; $display("FAIL rand_model[%0d]: got %b want %b", k, {CLK_OUT, TICK, PENDING, DIV_ERR}, model_out()); end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin m_phase[c] = 0; m_div[c] = DEF; m_nxt[c] = -1; end
    m_err = 0;
    test_reset;
    test_default_pattern;
    test_midperiod_write;
    test_double_write;
    test_disable;
    test_reset_priority;
    test_sync;
    test_invalid_channel;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_div_prog_multi.md
Name: clock_div_prog_multi

Overview:
Parametrised successor to the fixed 1 MHz -> 10 Hz divider. It divides one input clock into NUM_CH independent divided outputs. Each channel has a runtime-programmable divisor, a square-wave output and a one-cycle TICK strobe. Divisor changes are glitch-free: they take effect at the channel's period boundary. A SYNC input re-phases all channels together. It sits next to the avionics timing logic and feeds sensor sample rates and housekeeping timers from the 1 MHz system clock.

Parameters:
NUM_CH, 3, number of divided-clock channels (1..8)
CNT_W, 17, counter/divisor width in bits
DEFAULT_DIV, 100000, divisor loaded into every channel at reset (1 MHz -> 10 Hz)

Ports:
CLK_IN  input  1  input clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
DIV_WR  input  1  one-cycle write strobe for divisor
DIV_CH  input  3  channel index for write; values >= NUM_CH are ignored
DIV_DATA  input  CNT_W  new divisor value (output period in CLK_IN cycles)
SYNC  input  1  one-cycle strobe: restart all channels in phase
CLK_OUT  output  NUM_CH  divided square-wave outputs, one bit per channel
TICK  output  NUM_CH  one-cycle strobe on the last input cycle of each output period
PENDING  output  NUM_CH  per-channel: written divisor not yet applied
DIV_ERR  output  1  sticky: a write of divisor < 2 was accepted

Behaviour:
- Per-channel state: cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend flag.
- Reset (RESET=1 at a rising edge): cnt=0, div_act=div_pend=DEFAULT_DIV, pend=0, CLK_OUT=all 1, TICK=0, PENDING=0, DIV_ERR=0. A reset mid-period discards the period and any pending write.
- Registered outputs that match the same cycle's cnt: CLK_OUT[i]=1 while cnt < ceil(div_act/2), else 0. TICK[i]=1 only when cnt==div_act-1. The high phase is one cycle longer for odd divisors.
- Counting: if cnt==div_act-1, then cnt<=0 and, if pend=1, div_act<=div_pend and pend<=0. Otherwise cnt<=cnt+1. Period = div_act cycles exactly.
- Write: DIV_WR=1 with a valid DIV_CH sets div_pend<=DIV_DATA and pend<=1 for that channel. The active divisor is never changed mid-period.
- A second write before the boundary overwrites div_pend; only the last value is applied.
- DIV_DATA < 2 is accepted and sets DIV_ERR. When applied, the channel is disabled: cnt held at 0, CLK_OUT=0, TICK=0. A later write of a value >= 2 re-enables the channel. Because a disabled channel has no period boundary, that write applies on the next cycle, and the channel starts at cnt=0 with CLK_OUT=1.
- Write on the same cycle as a boundary for that channel: the write goes to pending and applies at the following boundary. The old pending value is still applied at the current boundary.
- SYNC=1: every channel sets cnt<=0. Any pending divisor, including a write on the same cycle, is applied immediately and pend is cleared. The next cycle shows cnt=0 and CLK_OUT=1 for enabled channels. TICK is not asserted by SYNC itself.
- RESET has priority over SYNC, and SYNC has priority over normal counting.
- DIV_CH >= NUM_CH: the write is dropped with no state change and no error.
- Arithmetic is unsigned CNT_W-bit. cnt never exceeds div_act-1, so there is no wrap-around. div_act = 2^CNT_W-1 is legal.

Test Plan:
- Reset, DEFAULT_DIV=4, NUM_CH=2 -> CLK_OUT pattern 1,1,0,0 repeating on both channels; TICK on every 4th cycle (cnt=3).
- Mid-period write DIV_DATA=5 to ch0 at cnt=1 -> PENDING[0]=1; old period completes in 4 cycles; then period 5 with high 3 / low 2; PENDING clears at the boundary.
- Two writes (6 then 3) to ch1 within one period -> only divisor 3 applied (high 2 / low 1); ch0 unaffected.
- Write 0 to ch0 -> DIV_ERR=1; after the boundary CLK_OUT[0]=0 and TICK[0]=0 held; write 4 -> next cycle cnt=0, CLK_OUT[0]=1, normal 4-cycle period.
- Channels at different phases, SYNC pulse with a same-cycle write of 6 to ch1 -> next cycle both at cnt=0, CLK_OUT=11, ch1 period 6 immediately, PENDING=00.
- RESET asserted together with SYNC and DIV_WR mid-period -> next cycle all state at reset values, divisor = DEFAULT_DIV, DIV_ERR=0.
